efpga_pwr_seq: RTL and testbench
================================

# efpga_pwr_seq

Power, isolation and reset sequencer for the eFPGA macro. It sits directly downstream of the SoC control register block: it consumes the EFPGA_CONTROL word, the type-1 reset bits and the in/out enable bits, and drives the physical power-enable, isolation, reset and interface-enable pins of the eFPGA. It returns a status word that the register block exposes at EFPGA_STATUS. Software requests a power state; this block guarantees a safe order of events and reports progress and errors.

## Interface
Parameters:
- PWR_TIMEOUT, 1024: HCLK cycles allowed for the power acknowledge before the block flags an error.
- RST_HOLD_MIN, 4: minimum reset hold in cycles. Applied when the programmed hold is smaller.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset. One clock; reset is asynchronous and active-low.
- control_in_i  in  32  control word. [0] power-on request; [1] force isolation; [15:8] reset hold cycles; other bits ignored.
- reset_type1_efpga_i  in  4  per-domain reset hold. 1 keeps that domain in reset even in ON.
- enable_inout_efpga_i  in  6  interface enables requested by software.
- efpga_pwr_ack_i  in  1  asynchronous power-good from the macro.
- efpga_pwr_en_o  out  1  power switch enable.
- efpga_iso_o  out  1  isolation. 1 = outputs clamped.
- efpga_rst_n_o  out  4  per-domain active-low resets.
- enable_inout_efpga_o  out  6  gated interface enables.
- status_out_o  out  32  status word.

## Operation
- efpga_pwr_ack_i passes through a 2-flop synchronizer before use (ack_s).
- FSM encoding: OFF=0, PWR_UP=1, RST_HOLD=2, ISO_REL=3, ON=4, ISO_SET=5, PWR_DN=6, ERROR=7.
- OFF: pwr_en=0, iso=1, rst_n=0. A request (bit 0 = 1) moves to PWR_UP, sets pwr_en, and clears the timeout counter.
- PWR_UP: wait for ack_s=1, then go to RST_HOLD and load the hold counter with max(control_in_i[15:8], RST_HOLD_MIN). If the timeout counter reaches PWR_TIMEOUT-1 first, go to ERROR.
- RST_HOLD: decrement the hold counter. At 0, release rst_n (domain i is released only if reset_type1_efpga_i[i]=0) and go to ISO_REL.
- ISO_REL: one cycle; iso goes to 0 on exit to ON.
- ON: enable_inout_efpga_o = enable_inout_efpga_i, registered. efpga_rst_n_o[i] = ~reset_type1_efpga_i[i], registered. Force isolation (bit 1) sets iso=1 and clears the enables while staying in ON.
- ON exits to ISO_SET on any of these: request drops, or ack_s drops (this also sets the sticky error).
- ISO_SET: enables=0 and iso=1. Next cycle rst_n=0 and the FSM goes to PWR_DN.
- PWR_DN: pwr_en=0. Wait for ack_s=0, then go to OFF. A timeout in PWR_DN goes to ERROR.
- ERROR: pwr_en=0, iso=1, rst_n=0, enables=0, sticky error=1. The FSM leaves to OFF only once request=0 and ack_s=0. The sticky error clears on the next request that leaves OFF.
- Request toggles mid-sequence:
  - a drop during PWR_UP, RST_HOLD or ISO_REL goes directly to ISO_SET;
  - a re-request during ISO_SET or PWR_DN is ignored until OFF is reached.
- status_out_o fields:
  - [2:0] state
  - [3] sticky error
  - [4] ack_s
  - [5] iso
  - [6] pwr_en
  - [15:8] hold counter
  - [31:16] timeout counter
- Counter widths: timeout is $clog2(PWR_TIMEOUT)+1 bits, zero-extended into status. Both counters saturate and never wrap.

## Timing
- Reset values: efpga_pwr_en_o=0, efpga_iso_o=1, efpga_rst_n_o=4'h0, enable_inout_efpga_o=6'h0, status_out_o=32'h0; FSM in OFF.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Request to pwr_en: 1 cycle.
- ack_i edge to observed transition: 2 cycles of synchronizer, plus 1 cycle of FSM.
- Rise of ack_s to rst_n release: hold+1 cycles. ISO_REL then adds 1 cycle before iso=0.
- ON to ISO_SET: iso=1 and enables=0 in the same cycle. rst_n=0 one cycle later; pwr_en=0 one cycle after that.
- An asynchronous reset mid-sequence forces the reset values immediately. The macro power is therefore cut with isolation held.

## Structure
- Shared package efpga_pwr_pkg holds:
  - the state enum efpga_pwr_state_e (3 bits);
  - control-bit index constants (CTRL_REQ=0, CTRL_FORCE_ISO=1, CTRL_HOLD_LSB=8);
  - status-field index constants.
- One sub-module, efpga_sync_2ff: a generic 2-flop synchronizer, asynchronous active-low reset, reset value 0.

## Test plan
- Normal power-up:
  - Stimulus: write control 0x0000_0801 with ack returned 5 cycles after pwr_en.
  - Expected: pwr_en at +1; rst_n=4'hF 8+1 cycles after ack_s; iso=0 one cycle later; status[2:0]=4.
- Hold clamp: control hold=1 → reset held for 4 cycles (RST_HOLD_MIN).
- Power-up timeout:
  - Stimulus: request with ack never returned.
  - Expected: ERROR after 1024 cycles; status[3]=1; pwr_en=0.
  - Follow-up: drop request → OFF. Re-request → status[3]=0.
- Type-1 reset and enables:
  - Stimulus: in ON, reset_type1=4'b0101 and enable=6'h3F.
  - Expected: rst_n=4'b1010 and enables=6'h3F one cycle later. Force-iso then gives iso=1 and enables=0 while the state stays 4.
- Power-down order:
  - Stimulus: drop request in ON.
  - Expected: iso=1 and enables=0 at +1; rst_n=0 at +2; pwr_en=0 at +3; OFF after ack falls plus 3 cycles.
- Faults:
  - Ack lost in ON → ISO_SET path runs and the sticky error is set.
  - HRESETn asserted in RST_HOLD → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/efpga_pwr_pkg.sv
// Shared types and field positions for the eFPGA power/isolation/reset sequencer.
package efpga_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_UP   = 3'd1,
    ST_RST_HOLD = 3'd2,
    ST_ISO_REL  = 3'd3,
    ST_ON       = 3'd4,
    ST_ISO_SET  = 3'd5,
    ST_PWR_DN   = 3'd6,
    ST_ERROR    = 3'd7
  } efpga_pwr_state_e;

  localparam int unsigned NUM_DOMAINS = 4;
  localparam int unsigned NUM_IFACE   = 6;
  localparam int unsigned HOLD_W      = 8;
  localparam int unsigned STATUS_W    = 32;

  localparam int unsigned CTRL_REQ       = 0;
  localparam int unsigned CTRL_FORCE_ISO = 1;
  localparam int unsigned CTRL_HOLD_LSB  = 8;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_ERR       = 3;
  localparam int unsigned STAT_ACK       = 4;
  localparam int unsigned STAT_ISO       = 5;
  localparam int unsigned STAT_PWR_EN    = 6;
  localparam int unsigned STAT_HOLD_LSB  = 8;
  localparam int unsigned STAT_TMO_LSB   = 16;

  // Programmed reset hold, raised to the floor when software asks for less.
  function automatic logic [HOLD_W-1:0] hold_clamp(input logic [HOLD_W-1:0] prog,
                                                   input int unsigned min_hold);
    hold_clamp = (prog < HOLD_W'(min_hold)) ? HOLD_W'(min_hold) : prog;
  endfunction

endpackage

// File: rtl/efpga_sync_2ff.sv
// Generic two-flop synchronizer, clears to zero on reset.
module efpga_sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/efpga_pwr_seq.sv
// Power, isolation and reset sequencer for the eFPGA macro; every output is a flop
// so the macro pins never see a combinational path from software or the ack pin.
module efpga_pwr_seq
  import efpga_pwr_pkg::*;
#(
  parameter int unsigned PWR_TIMEOUT  = 1024,
  parameter int unsigned RST_HOLD_MIN = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [STATUS_W-1:0]    control_in_i,
  input  logic [NUM_DOMAINS-1:0] reset_type1_efpga_i,
  input  logic [NUM_IFACE-1:0]   enable_inout_efpga_i,
  input  logic                   efpga_pwr_ack_i,
  output logic                   efpga_pwr_en_o,
  output logic                   efpga_iso_o,
  output logic [NUM_DOMAINS-1:0] efpga_rst_n_o,
  output logic [NUM_IFACE-1:0]   enable_inout_efpga_o,
  output logic [STATUS_W-1:0]    status_out_o
);

  localparam int unsigned TMO_W = $clog2(PWR_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PWR_TIMEOUT - 1);

  efpga_pwr_state_e        state, state_n;
  logic                    pwr_en_n, iso_n, err_q, err_n, ack_s;
  logic [NUM_DOMAINS-1:0]  rst_n_n;
  logic [NUM_IFACE-1:0]    en_n, en_req;
  logic [HOLD_W-1:0]       hold_q, hold_n, hold_load;
  logic [TMO_W-1:0]        tmo_q, tmo_n, tmo_inc;
  logic [STATUS_W-1:0]     status_n;
  logic                    req, force_iso, unused_ctrl;

  efpga_sync_2ff #(.W(1)) u_ack_sync (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .d     (efpga_pwr_ack_i),
    .q     (ack_s)
  );

  assign req         = control_in_i[CTRL_REQ];
  assign force_iso   = control_in_i[CTRL_FORCE_ISO];
  assign hold_load   = hold_clamp(control_in_i[CTRL_HOLD_LSB +: HOLD_W], RST_HOLD_MIN);
  assign en_req      = force_iso ? '0 : enable_inout_efpga_i;
  assign tmo_inc     = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
  assign unused_ctrl = ^{control_in_i[STATUS_W-1:CTRL_HOLD_LSB+HOLD_W],
                         control_in_i[CTRL_HOLD_LSB-1:CTRL_FORCE_ISO+1]};

  // Next state and next value of every registered output.
  always_comb begin
    state_n  = state;
    pwr_en_n = efpga_pwr_en_o;
    iso_n    = efpga_iso_o;
    rst_n_n  = efpga_rst_n_o;
    en_n     = enable_inout_efpga_o;
    hold_n   = hold_q;
    tmo_n    = tmo_q;
    err_n    = err_q;
    case (state)
      ST_OFF: begin
        pwr_en_n = 1'b0;
        iso_n    = 1'b1;
        rst_n_n  = '0;
        en_n     = '0;
        if (req) begin
          state_n  = ST_PWR_UP;
          pwr_en_n = 1'b1;
          tmo_n    = '0;
          err_n    = 1'b0;
        end
      end
      ST_PWR_UP: begin
        if (!req) begin
          state_n = ST_ISO_SET;
        end else if (ack_s) begin
          state_n = ST_RST_HOLD;
          hold_n  = hold_load;
        end else if (tmo_q == TMO_LAST) begin
          state_n  = ST_ERROR;
          pwr_en_n = 1'b0;
          err_n    = 1'b1;
        end else begin
          tmo_n = tmo_inc;
        end
      end
      ST_RST_HOLD: begin
        if (!req) begin
          state_n = ST_ISO_SET;
        end else if (hold_q == '0) begin
          state_n = ST_ISO_REL;
          rst_n_n = ~reset_type1_efpga_i;
        end else begin
          hold_n = hold_q - HOLD_W'(1);
        end
      end
      ST_ISO_REL: begin
        if (!req) begin
          state_n = ST_ISO_SET;
        end else begin
          state_n = ST_ON;
          iso_n   = force_iso;
          en_n    = en_req;
          rst_n_n = ~reset_type1_efpga_i;
        end
      end
      ST_ON: begin
        if (!req || !ack_s) begin
          // Clamp first; resets and power follow one cycle apart.
          state_n = ST_ISO_SET;
          iso_n   = 1'b1;
          en_n    = '0;
          if (!ack_s) err_n = 1'b1;
        end else begin
          iso_n   = force_iso;
          en_n    = en_req;
          rst_n_n = ~reset_type1_efpga_i;
        end
      end
      ST_ISO_SET: begin
        state_n = ST_PWR_DN;
        iso_n   = 1'b1;
        en_n    = '0;
        rst_n_n = '0;
        tmo_n   = '0;
      end
      ST_PWR_DN: begin
        pwr_en_n = 1'b0;
        if (!ack_s) begin
          state_n = ST_OFF;
        end else if (tmo_q == TMO_LAST) begin
          state_n = ST_ERROR;
          err_n   = 1'b1;
        end else begin
          tmo_n = tmo_inc;
        end
      end
      ST_ERROR: begin
        pwr_en_n = 1'b0;
        iso_n    = 1'b1;
        rst_n_n  = '0;
        en_n     = '0;
        err_n    = 1'b1;
        if (!req && !ack_s) state_n = ST_OFF;
      end
      default: state_n = ST_OFF;
    endcase
  end

  always_comb begin
    status_n                               = '0;
    status_n[STAT_STATE_LSB +: 3]          = state_n;
    status_n[STAT_ERR]                     = err_n;
    status_n[STAT_ACK]                     = ack_s;
    status_n[STAT_ISO]                     = iso_n;
    status_n[STAT_PWR_EN]                  = pwr_en_n;
    status_n[STAT_HOLD_LSB +: HOLD_W]      = hold_n;
    status_n[STAT_TMO_LSB +: 16]           = 16'(tmo_n);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state                <= ST_OFF;
      efpga_pwr_en_o       <= 1'b0;
      efpga_iso_o          <= 1'b1;
      efpga_rst_n_o        <= '0;
      enable_inout_efpga_o <= '0;
      hold_q               <= '0;
      tmo_q                <= '0;
      err_q                <= 1'b0;
      status_out_o         <= '0;
    end else begin
      state                <= state_n;
      efpga_pwr_en_o       <= pwr_en_n;
      efpga_iso_o          <= iso_n;
      efpga_rst_n_o        <= rst_n_n;
      enable_inout_efpga_o <= en_n;
      hold_q               <= hold_n;
      tmo_q                <= tmo_n;
      err_q                <= err_n;
      status_out_o         <= status_n;
    end
  end

endmodule

// File: tb/tb_efpga_pwr_seq.sv
// Randomized sequence bench for efpga_pwr_seq; expectations are event latencies and
// pin levels derived from the sequencing rules, not from the RTL's internals.
module tb_efpga_pwr_seq;

  localparam int unsigned TMO  = 1024;
  localparam int unsigned HMIN = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] control_in_i = '0;
  logic [3:0]  reset_type1_efpga_i = '0;
  logic [5:0]  enable_inout_efpga_i = '0;
  logic        efpga_pwr_ack_i = 1'b0;
  logic        efpga_pwr_en_o, efpga_iso_o;
  logic [3:0]  efpga_rst_n_o;
  logic [5:0]  enable_inout_efpga_o;
  logic [31:0] status_out_o;

  int checks = 0;
  int errors = 0;

  efpga_pwr_seq #(.PWR_TIMEOUT(TMO), .RST_HOLD_MIN(HMIN)) dut (
    .HCLK                 (HCLK),
    .HRESETn              (HRESETn),
    .control_in_i         (control_in_i),
    .reset_type1_efpga_i  (reset_type1_efpga_i),
    .enable_inout_efpga_i (enable_inout_efpga_i),
    .efpga_pwr_ack_i      (efpga_pwr_ack_i),
    .efpga_pwr_en_o       (efpga_pwr_en_o),
    .efpga_iso_o          (efpga_iso_o),
    .efpga_rst_n_o        (efpga_rst_n_o),
    .enable_inout_efpga_o (enable_inout_efpga_o),
    .status_out_o         (status_out_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  function automatic logic [31:0] st();
    return 32'(status_out_o[2:0]);
  endfunction

  // Effective reset hold after the floor is applied.
  function automatic int hold_eff(input int h);
    return (h < int'(HMIN)) ? int'(HMIN) : h;
  endfunction

  function automatic logic [31:0] ctrl_word(input int h, input logic req, input logic fiso);
    return {16'h0, 8'(h), 6'h0, fiso, req};
  endfunction

  // Request power, return ack after ack_dly cycles, and follow the sequence into ON.
  task automatic power_up(input int h, input int ack_dly, input logic [3:0] t1);
    int n;
    logic [3:0] exp_rst;
    exp_rst = ~t1;
    reset_type1_efpga_i = t1;
    control_in_i = ctrl_word(h, 1'b1, 1'b0);
    tick();
    check("pwr_en_rise", 32'(efpga_pwr_en_o), 32'd1);
    check("st_pwr_up", st(), 32'd1);
    check("err_cleared", 32'(status_out_o[3]), 32'd0);
    repeat (ack_dly - 1) tick();
    efpga_pwr_ack_i = 1'b1;
    n = 0;
    while (st() != 32'd2 && n < 50) begin tick(); n++; end
    check("ack_latency", 32'(n), 32'd3);
    check("hold_loaded", 32'(status_out_o[15:8]), 32'(hold_eff(h)));
    check("rst_held", 32'(efpga_rst_n_o), 32'd0);
    n = 0;
    while (st() == 32'd2 && n < 300) begin tick(); n++; end
    check("hold_length", 32'(n), 32'(hold_eff(h) + 1));
    check("st_iso_rel", st(), 32'd3);
    check("rst_release", 32'(efpga_rst_n_o), 32'(exp_rst));
    check("iso_still_on", 32'(efpga_iso_o), 32'd1);
    tick();
    check("st_on", st(), 32'd4);
    check("iso_released", 32'(efpga_iso_o), 32'd0);
    check("pwr_en_on", 32'(efpga_pwr_en_o), 32'd1);
  endtask

  // Exercise type-1 resets, enables and force isolation while ON.
  task automatic on_checks(input int h, input logic [3:0] t1, input logic [5:0] en);
    logic [3:0] exp_rst;
    exp_rst = ~t1;
    reset_type1_efpga_i  = t1;
    enable_inout_efpga_i = en;
    tick();
    check("on_rst_type1", 32'(efpga_rst_n_o), 32'(exp_rst));
    check("on_enables", 32'(enable_inout_efpga_o), 32'(en));
    control_in_i = ctrl_word(h, 1'b1, 1'b1);
    tick();
    check("force_iso", 32'(efpga_iso_o), 32'd1);
    check("force_en_off", 32'(enable_inout_efpga_o), 32'd0);
    check("force_st_on", st(), 32'd4);
    control_in_i = ctrl_word(h, 1'b1, 1'b0);
    tick();
    check("unforce_iso", 32'(efpga_iso_o), 32'd0);
    check("unforce_en", 32'(enable_inout_efpga_o), 32'(en));
  endtask

  // Drop the request in ON and check clamp, reset, power order then OFF.
  task automatic power_down(input int h, input int ack_gap);
    int n;
    logic [3:0] exp_rst;
    exp_rst = ~reset_type1_efpga_i;
    control_in_i = ctrl_word(h, 1'b0, 1'b0);
    tick();
    check("dn1_state", st(), 32'd5);
    check("dn1_iso", 32'(efpga_iso_o), 32'd1);
    check("dn1_en", 32'(enable_inout_efpga_o), 32'd0);
    check("dn1_rst", 32'(efpga_rst_n_o), 32'(exp_rst));
    check("dn1_pwr", 32'(efpga_pwr_en_o), 32'd1);
    tick();
    check("dn2_rst", 32'(efpga_rst_n_o), 32'd0);
    check("dn2_pwr", 32'(efpga_pwr_en_o), 32'd1);
    tick();
    check("dn3_pwr", 32'(efpga_pwr_en_o), 32'd0);
    check("dn3_state", st(), 32'd6);
    repeat (ack_gap) tick();
    efpga_pwr_ack_i = 1'b0;
    n = 0;
    while (st() != 32'd0 && n < 50) begin tick(); n++; end
    check("off_latency", 32'(n), 32'd3);
    check("off_no_err", 32'(status_out_o[3]), 32'd0);
  endtask

  initial begin
    int n, h;
    #12;
    check("rst_pwr_en", 32'(efpga_pwr_en_o), 32'd0);
    check("rst_iso", 32'(efpga_iso_o), 32'd1);
    check("rst_rst_n", 32'(efpga_rst_n_o), 32'd0);
    check("rst_en", 32'(enable_inout_efpga_o), 32'd0);
    check("rst_status", status_out_o, 32'd0);
    tick();
    HRESETn = 1'b1;
    tick();
    check("idle_state", st(), 32'd0);
    check("idle_iso", 32'(status_out_o[5]), 32'd1);

    for (int i = 0; i < 6; i++) begin
      int dly;
      logic [3:0] t1;
      h   = (i == 0) ? 8 : (i == 1) ? 1 : int'($urandom_range(0, 20));
      dly = (i == 0) ? 5 : int'($urandom_range(1, 8));
      t1  = (i < 2) ? 4'h0 : 4'($urandom);
      power_up(h, dly, t1);
      on_checks(h, (i == 0) ? 4'b0101 : 4'($urandom), (i == 0) ? 6'h3F : 6'($urandom));
      power_down(h, int'($urandom_range(0, 3)));
    end

    // Power-up timeout, recovery, and drop during PWR_UP.
    control_in_i = ctrl_word(0, 1'b1, 1'b0);
    n = 0;
    while (st() != 32'd7 && n < 3000) begin tick(); n++; end
    check("tmo_latency", 32'(n), 32'(TMO + 1));
    check("tmo_err", 32'(status_out_o[3]), 32'd1);
    check("tmo_pwr_en", 32'(efpga_pwr_en_o), 32'd0);
    check("tmo_iso", 32'(efpga_iso_o), 32'd1);
    check("tmo_count", 32'(status_out_o[31:16]), 32'(TMO - 1));
    control_in_i = ctrl_word(0, 1'b0, 1'b0);
    tick();
    check("tmo_off", st(), 32'd0);
    check("tmo_err_sticky", 32'(status_out_o[3]), 32'd1);
    control_in_i = ctrl_word(0, 1'b1, 1'b0);
    tick();
    check("rereq_state", st(), 32'd1);
    check("rereq_err_clr", 32'(status_out_o[3]), 32'd0);
    control_in_i = ctrl_word(0, 1'b0, 1'b0);
    tick();
    check("drop_pwrup_iso_set", st(), 32'd5);
    tick();
    check("drop_pwrup_pwr_dn", st(), 32'd6);
    tick();
    check("drop_pwrup_off", st(), 32'd0);

    // Ack lost while ON.
    h = int'($urandom_range(0, 10));
    power_up(h, 2, 4'h0);
    efpga_pwr_ack_i = 1'b0;
    n = 0;
    while (st() != 32'd5 && n < 50) begin tick(); n++; end
    check("acklost_latency", 32'(n), 32'd3);
    check("acklost_err", 32'(status_out_o[3]), 32'd1);
    check("acklost_iso", 32'(efpga_iso_o), 32'd1);
    check("acklost_en", 32'(enable_inout_efpga_o), 32'd0);
    control_in_i = ctrl_word(h, 1'b0, 1'b0);
    tick();
    check("acklost_rst", 32'(efpga_rst_n_o), 32'd0);
    tick();
    check("acklost_off", st(), 32'd0);
    check("acklost_err_off", 32'(status_out_o[3]), 32'd1);

    // Asynchronous reset during RST_HOLD.
    control_in_i = ctrl_word(12, 1'b1, 1'b0);
    tick();
    efpga_pwr_ack_i = 1'b1;
    n = 0;
    while (st() != 32'd2 && n < 50) begin tick(); n++; end
    check("ar_reach_hold", st(), 32'd2);
    tick(); tick();
    #2 HRESETn = 1'b0;
    #1;
    check("ar_pwr_en", 32'(efpga_pwr_en_o), 32'd0);
    check("ar_iso", 32'(efpga_iso_o), 32'd1);
    check("ar_rst_n", 32'(efpga_rst_n_o), 32'd0);
    check("ar_en", 32'(enable_inout_efpga_o), 32'd0);
    check("ar_status", status_out_o, 32'd0);
    control_in_i = '0;
    efpga_pwr_ack_i = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    check("ar_after_state", st(), 32'd0);
    check("ar_after_pwr", 32'(efpga_pwr_en_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
